demux1t2_32: RTL and testbench



---
 rtl/demux1t2_32_pkg.sv | 22 ++
 rtl/demux1t2_32_if.sv | 35 +++
 rtl/demux1t2_32_out_slot.sv | 57 +++++
 rtl/demux1t2_32.sv | 87 ++++++++
 tb/tb_demux1t2_32.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux1t2_32_pkg.sv
// Shared types and constants for the registered 1-to-2 word demultiplexer.
// Imported by the slot, the top level and the testbench.
package demux1t2_32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    // Steering mode encodings on the mode input.
    localparam logic MODE_STEER = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output index; doubles as the round-robin FSM state.
    typedef enum logic {
        SEL0 = 1'b0,
        SEL1 = 1'b1
    } sel_t;

    function automatic sel_t other_sel(input sel_t s);
        return (s == SEL0) ? SEL1 : SEL0;
    endfunction

endpackage

// File: rtl/demux1t2_32_if.sv
// Bundle of the source channel, both sink channels and status outputs of demux1t2_32.
// master = environment side (producer + consumers), slave = the demux itself.
interface demux1t2_32_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] I;
    logic             S;
    logic             mode;

    logic             o0_valid;
    logic             o0_ready;
    logic [WIDTH-1:0] o0;

    logic             o1_valid;
    logic             o1_ready;
    logic [WIDTH-1:0] o1;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             rr_sel;

    modport master (
        output I_valid, I, S, mode, o0_ready, o1_ready,
        input  I_ready, o0_valid, o0, o1_valid, o1, cnt0, cnt1, rr_sel
    );

    modport slave (
        input  I_valid, I, S, mode, o0_ready, o1_ready,
        output I_ready, o0_valid, o0, o1_valid, o1, cnt0, cnt1, rr_sel
    );

endinterface

// File: rtl/demux1t2_32_out_slot.sv
// One-entry output holding register with its own delivered-word counter.
// A load in the same cycle as a delivery keeps the slot full with the new word.
module demux1t2_32_out_slot
    import demux1t2_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             deliver;

    assign deliver = valid_q && ready_i;

    // Load is applied after the drain so a same-cycle refill wins over the clear.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (deliver) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o  = data_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1t2_32.sv
// Registered 1-to-2 word demultiplexer with explicit (S) or round-robin steering.
// Top level holds target selection, the input ready and the round-robin FSM.
module demux1t2_32
    import demux1t2_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    demux1t2_32_if.slave  bus
);

    sel_t rr_q, rr_d;
    sel_t target;
    logic tgt_valid;
    logic tgt_ready;
    logic accept;
    logic load0, load1;
    logic slot0_valid, slot1_valid;

    // Target depends only on mode/S/rr state, never on I_valid.
    always_comb begin
        target    = (bus.mode == MODE_RR) ? rr_q : sel_t'(bus.S);
        tgt_valid = (target == SEL1) ? slot1_valid  : slot0_valid;
        tgt_ready = (target == SEL1) ? bus.o1_ready : bus.o0_ready;
    end

    assign bus.I_ready = !tgt_valid || tgt_ready;
    assign accept      = bus.I_valid && bus.I_ready;
    assign load0       = accept && (target == SEL0);
    assign load1       = accept && (target == SEL1);

    // Pointer only moves on words actually accepted in round-robin mode.
    always_comb begin
        rr_d = rr_q;
        if (accept && (bus.mode == MODE_RR)) begin
            case (rr_q)
                SEL0:    rr_d = SEL1;
                SEL1:    rr_d = SEL0;
                default: rr_d = SEL0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= SEL0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign bus.rr_sel = (rr_q == SEL1);

    demux1t2_32_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load0),
        .din_i   (bus.I),
        .ready_i (bus.o0_ready),
        .dout_o  (bus.o0),
        .valid_o (slot0_valid),
        .cnt_o   (bus.cnt0)
    );

    demux1t2_32_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load1),
        .din_i   (bus.I),
        .ready_i (bus.o1_ready),
        .dout_o  (bus.o1),
        .valid_o (slot1_valid),
        .cnt_o   (bus.cnt1)
    );

    assign bus.o0_valid = slot0_valid;
    assign bus.o1_valid = slot1_valid;

endmodule

// File: tb/tb_demux1t2_32.sv
// Scoreboard bench for demux1t2_32: accepted words are queued per sink and a
// monitor pops and compares on every delivery handshake.
module tb_demux1t2_32;
    import demux1t2_32_pkg::*;

    localparam int W  = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux1t2_32_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux1t2_32 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    logic rrModel = 1'b0;
    logic [W-1:0] monWord;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Delivery monitor: every handshake must match the oldest word queued for that sink.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o0_valid && bus.o0_ready) begin
                nChecks++;
                if (exp0.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL o0_unexpected: got %h expected no delivery at %0t", bus.o0, $time);
                end else begin
                    monWord = exp0.pop_front();
                    if (bus.o0 !== monWord) begin
                        nFails++;
                        $display("[TB] FAIL o0_data: got %h expected %h at %0t", bus.o0, monWord, $time);
                    end
                end
            end
            if (bus.o1_valid && bus.o1_ready) begin
                nChecks++;
                if (exp1.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL o1_unexpected: got %h expected no delivery at %0t", bus.o1, $time);
                end else begin
                    monWord = exp1.pop_front();
                    if (bus.o1 !== monWord) begin
                        nFails++;
                        $display("[TB] FAIL o1_data: got %h expected %h at %0t", bus.o1, monWord, $time);
                    end
                end
            end
        end
    end

    task automatic nextCycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        bus.I_valid = 1'b0;
        rst = 1'b1;
        nextCycle(1);
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
        rrModel = 1'b0;
    endtask

    // Present one word and hold it until accepted; queue it for the sink the bench predicts.
    task automatic applyStimulus(input logic [W-1:0] d, input logic s);
        logic tgt;
        bit done;
        done = 1'b0;
        bus.I = d;
        bus.S = s;
        bus.I_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.I_ready) begin
                tgt = bus.mode ? rrModel : s;
                if (tgt) exp1.push_back(d);
                else     exp0.push_back(d);
                if (bus.mode) rrModel = ~rrModel;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.I_valid = 1'b0;
        if (!done) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance of %h", d);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.I_valid  = 1'b0;
        bus.I        = '0;
        bus.S        = 1'b0;
        bus.mode     = MODE_STEER;
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;
        nextCycle(2);
        doReset();

        // Reset state
        checkOutput("rst_o0_valid", W'(bus.o0_valid), 0);
        checkOutput("rst_o1_valid", W'(bus.o1_valid), 0);
        checkOutput("rst_o0", bus.o0, 0);
        checkOutput("rst_o1", bus.o1, 0);
        checkOutput("rst_cnt0", W'(bus.cnt0), 0);
        checkOutput("rst_cnt1", W'(bus.cnt1), 0);
        checkOutput("rst_rr_sel", W'(bus.rr_sel), 0);

        // Mode 0 routing to o0
        applyStimulus(32'hDEADBEEF, 1'b0);
        checkOutput("m0_o0_valid", W'(bus.o0_valid), 1);
        checkOutput("m0_o0", bus.o0, 32'hDEADBEEF);
        checkOutput("m0_o1_valid", W'(bus.o1_valid), 0);
        nextCycle(1);
        checkOutput("m0_cnt0", W'(bus.cnt0), 1);
        checkOutput("m0_o0_drained", W'(bus.o0_valid), 0);

        // Backpressure on o1
        doReset();
        bus.o1_ready = 1'b0;
        applyStimulus(32'h11111111, 1'b1);
        bus.I = 32'h22222222;
        bus.S = 1'b1;
        bus.I_valid = 1'b1;
        #1;
        checkOutput("bp_ready_low", W'(bus.I_ready), 0);
        nextCycle(2);
        checkOutput("bp_ready_still_low", W'(bus.I_ready), 0);
        checkOutput("bp_o1_hold", bus.o1, 32'h11111111);
        checkOutput("bp_o1_valid", W'(bus.o1_valid), 1);
        bus.o1_ready = 1'b1;
        #1;
        checkOutput("bp_ready_high", W'(bus.I_ready), 1);
        applyStimulus(32'h22222222, 1'b1);
        checkOutput("bp_o1_new", bus.o1, 32'h22222222);
        checkOutput("bp_o1_valid2", W'(bus.o1_valid), 1);
        nextCycle(1);
        checkOutput("bp_cnt1", W'(bus.cnt1), 2);

        // Round-robin alternation
        doReset();
        bus.mode = MODE_RR;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(W'(i), 1'b0);
            checkOutput("rr_sel_toggle", W'(bus.rr_sel), (i % 2 == 1) ? 1 : 0);
        end
        nextCycle(2);
        checkOutput("rr_cnt0", W'(bus.cnt0), 2);
        checkOutput("rr_cnt1", W'(bus.cnt1), 2);
        checkOutput("rr_sel_final", W'(bus.rr_sel), 0);

        // Mode 0 holds the pointer
        bus.mode = MODE_STEER;
        applyStimulus(32'hA5A5A5A5, 1'b1);
        checkOutput("m0_rr_hold", W'(bus.rr_sel), 0);
        nextCycle(1);

        // Simultaneous drain and fill on o0
        doReset();
        bus.o0_ready = 1'b0;
        applyStimulus(32'hAAAA0001, 1'b0);
        bus.o0_ready = 1'b1;
        bus.S = 1'b0;
        #1;
        checkOutput("df_ready", W'(bus.I_ready), 1);
        applyStimulus(32'hBBBB0002, 1'b0);
        checkOutput("df_o0_valid", W'(bus.o0_valid), 1);
        checkOutput("df_o0_new", bus.o0, 32'hBBBB0002);
        checkOutput("df_cnt0", W'(bus.cnt0), 1);
        nextCycle(1);
        checkOutput("df_cnt0_after", W'(bus.cnt0), 2);
        checkOutput("df_o0_empty", W'(bus.o0_valid), 0);

        // Counter wrap with a 4-bit counter: 17 deliveries on o1
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(32'hC0DE0000 + W'(i), 1'b1);
        end
        nextCycle(1);
        checkOutput("wrap_cnt1", W'(bus.cnt1), 1);
        checkOutput("wrap_cnt0", W'(bus.cnt0), 0);

        // Reset mid-operation with both slots full
        doReset();
        bus.o0_ready = 1'b0;
        bus.o1_ready = 1'b0;
        applyStimulus(32'h0F0F0F0F, 1'b0);
        applyStimulus(32'hF0F0F0F0, 1'b1);
        checkOutput("mr_full0", W'(bus.o0_valid), 1);
        checkOutput("mr_full1", W'(bus.o1_valid), 1);
        doReset();
        checkOutput("mr_o0_valid", W'(bus.o0_valid), 0);
        checkOutput("mr_o1_valid", W'(bus.o1_valid), 0);
        checkOutput("mr_o0", bus.o0, 0);
        checkOutput("mr_o1", bus.o1, 0);
        checkOutput("mr_cnt0", W'(bus.cnt0), 0);
        checkOutput("mr_cnt1", W'(bus.cnt1), 0);
        checkOutput("mr_rr_sel", W'(bus.rr_sel), 0);
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;
        nextCycle(3);
        checkOutput("mr_no_stale0", W'(bus.cnt0), 0);
        checkOutput("mr_no_stale1", W'(bus.cnt1), 0);

        checkOutput("sb_empty0", W'(exp0.size()), 0);
        checkOutput("sb_empty1", W'(exp1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
